// File: rtl/ysyx_22041752_ifu_fq_pkg.sv
// Shared definitions for the ysyx_22041752 fetch unit: RV32 control-flow opcodes,
// immediate widths, the reset PC and the fetch-queue entry layout.
package ysyx_22041752_ifu_fq_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int IMM_I_WD = 12;
  localparam int IMM_B_WD = 13;
  localparam int IMM_J_WD = 21;

  typedef enum logic [1:0] {
    CF_NONE,
    CF_JAL,
    CF_JALR,
    CF_BRANCH
  } cf_kind_e;

  // Queue entries are packed MSB-first as {inst, pc, taken, target}.
  function automatic int fq_entry_wd(input int inst_wd, input int pc_wd);
    return inst_wd + pc_wd + 1 + pc_wd;
  endfunction

  function automatic cf_kind_e cf_kind(input logic [6:0] opcode);
    cf_kind_e kind;
    case (opcode)
      OPC_JAL:    kind = CF_JAL;
      OPC_JALR:   kind = CF_JALR;
      OPC_BRANCH: kind = CF_BRANCH;
      default:    kind = CF_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/ysyx_22041752_fq_fifo.sv
// Generic DEPTH x WIDTH synchronous circular FIFO with clear, occupancy count,
// full and empty; the head is read straight from the storage registers.
module ysyx_22041752_fq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_WD = $clog2(DEPTH);
  localparam logic [PTR_WD:0] FULL_CNT = (PTR_WD+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_WD-1:0] wr_ptr;
  logic [PTR_WD-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  // A push while full is only legal when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_WD'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_WD'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_WD+1)'(1);
        2'b01:   count <= count - (PTR_WD+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22041752_ifu_fq.sv
// Decoupled instruction-fetch unit: credit-limited pipelined I-cache requests, static
// prediction, flush redirect and a fetch queue toward decode. Optional IFU_PERF_CNT_EN
// adds saturating drop/starve performance counters.
module ysyx_22041752_ifu_fq
  import ysyx_22041752_ifu_fq_pkg::*;
#(
  parameter int              PC_WD    = 32,
  parameter int              INST_WD  = 32,
  parameter logic [PC_WD-1:0] RESET_PC = PC_WD'(RESET_PC_DEF),
  parameter int              FQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        ireq_valid,
  input  logic                        ireq_ready,
  output logic [PC_WD-1:0]            ireq_addr,
  input  logic                        iresp_valid,
  input  logic [INST_WD-1:0]          iresp_data,
  input  logic                        flush,
  input  logic [PC_WD-1:0]            flush_pc,
  input  logic [PC_WD-1:0]            ra_data,
  output logic                        fq_valid,
  input  logic                        fq_ready,
  output logic [INST_WD-1:0]          fq_inst,
  output logic [PC_WD-1:0]            fq_pc,
  output logic                        fq_pred_taken,
  output logic [PC_WD-1:0]            fq_pred_target,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_drop_cnt,
  output logic [31:0]                 perf_starve_cnt
`endif
);

  localparam int CNT_WD   = $clog2(FQ_DEPTH) + 1;
  localparam int ENTRY_WD = fq_entry_wd(INST_WD, PC_WD);
  localparam logic [CNT_WD:0] CREDIT_MAX = (CNT_WD+1)'(FQ_DEPTH);

  // Handshake rule on both sides: a transfer happens on a rising clk edge where
  // valid and ready are both high; valid never depends on ready.
  logic [PC_WD-1:0]    req_pc;
  logic [PC_WD-1:0]    resp_pc;
  logic [CNT_WD-1:0]   inflight;
  logic [CNT_WD-1:0]   drop_cnt;
  logic [CNT_WD:0]     credit_used;
  logic                req_fire;
  logic                resp_drop;
  logic                resp_push;
  logic                fq_pop;
  logic                fq_empty;
  logic                fq_full;
  logic [ENTRY_WD-1:0] push_entry;
  logic [ENTRY_WD-1:0] head_entry;

  logic [IMM_J_WD-1:0] imm_j;
  logic [IMM_I_WD-1:0] imm_i;
  logic [IMM_B_WD-1:0] imm_b;
  logic [PC_WD-1:0]    off_j;
  logic [PC_WD-1:0]    off_i;
  logic [PC_WD-1:0]    off_b;
  logic [PC_WD-1:0]    jalr_sum;
  logic                pred_taken;
  logic [PC_WD-1:0]    pred_target;

  // A pop in the same cycle does not free a credit; the queue plus outstanding
  // requests can therefore never exceed FQ_DEPTH.
  assign credit_used = {1'b0, fq_count} + {1'b0, inflight};
  assign ireq_valid  = reset && !flush && (credit_used < CREDIT_MAX);
  assign ireq_addr   = req_pc;
  assign req_fire    = ireq_valid && ireq_ready;

  assign resp_drop   = iresp_valid && (drop_cnt != '0);
  assign resp_push   = iresp_valid && (drop_cnt == '0) && !flush && (!fq_full || fq_pop);

  assign fq_valid    = !flush && !fq_empty;
  assign fq_pop      = fq_valid && fq_ready;

  assign imm_j = {iresp_data[31], iresp_data[19:12], iresp_data[20], iresp_data[30:21], 1'b0};
  assign imm_i = iresp_data[31:20];
  assign imm_b = {iresp_data[31], iresp_data[7], iresp_data[30:25], iresp_data[11:8], 1'b0};
  assign off_j = {{(PC_WD-IMM_J_WD){imm_j[IMM_J_WD-1]}}, imm_j};
  assign off_i = {{(PC_WD-IMM_I_WD){imm_i[IMM_I_WD-1]}}, imm_i};
  assign off_b = {{(PC_WD-IMM_B_WD){imm_b[IMM_B_WD-1]}}, imm_b};
  assign jalr_sum = ra_data + off_i;

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = resp_pc + PC_WD'(4);
    case (cf_kind(iresp_data[6:0]))
      CF_JAL: begin
        pred_taken  = 1'b1;
        pred_target = resp_pc + off_j;
      end
      CF_JALR: begin
        pred_taken  = 1'b1;
        pred_target = jalr_sum & {{(PC_WD-1){1'b1}}, 1'b0};
      end
      CF_BRANCH: begin
        if (imm_b[IMM_B_WD-1]) begin
          pred_taken  = 1'b1;
          pred_target = resp_pc + off_b;
        end
      end
      default: begin
        pred_taken = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_pc   <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CNT_WD'(req_fire) - CNT_WD'(iresp_valid);
      if (flush) begin
        req_pc   <= flush_pc;
        resp_pc  <= flush_pc;
        drop_cnt <= inflight - CNT_WD'(iresp_valid);
      end else begin
        if (req_fire) begin
          req_pc <= req_pc + PC_WD'(4);
        end
        if (resp_drop) begin
          drop_cnt <= drop_cnt - CNT_WD'(1);
        end else if (iresp_valid) begin
          resp_pc <= pred_target;
          // Everything still outstanding, including a request accepted right now,
          // was fetched down the fall-through path and must be discarded.
          if (pred_taken) begin
            req_pc   <= pred_target;
            drop_cnt <= inflight - CNT_WD'(1) + CNT_WD'(req_fire);
          end
        end
      end
    end
  end

  assign push_entry = {iresp_data, resp_pc, pred_taken, pred_target};

  ysyx_22041752_fq_fifo #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (ENTRY_WD)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (flush),
    .push      (resp_push),
    .push_data (push_entry),
    .pop       (fq_pop),
    .head_data (head_entry),
    .count     (fq_count),
    .full      (fq_full),
    .empty     (fq_empty)
  );

  assign {fq_inst, fq_pc, fq_pred_taken, fq_pred_target} = head_entry;

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_drop_cnt   <= '0;
      perf_starve_cnt <= '0;
    end else begin
      if (iresp_valid && (flush || drop_cnt != '0) && (perf_drop_cnt != '1)) begin
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
      end
      if (fq_ready && !fq_valid && (perf_starve_cnt != '1)) begin
        perf_starve_cnt <= perf_starve_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22041752_ifu_fq.sv
// Bench for ysyx_22041752_ifu_fq: random I-cache and decode traffic, flushes and resets;
// the fetch-queue stream is scoreboarded against a predicted-path program model.
`timescale 1ns/1ps
module tb_ysyx_22041752_ifu_fq;

  localparam int PC_WD    = 32;
  localparam int INST_WD  = 32;
  localparam int FQ_DEPTH = 4;
  localparam int CNT_WD   = $clog2(FQ_DEPTH) + 1;
  localparam int EW       = INST_WD + PC_WD + 1 + PC_WD;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic               ireq_valid;
  logic               ireq_ready = 1'b0;
  logic [PC_WD-1:0]   ireq_addr;
  logic               iresp_valid = 1'b0;
  logic [INST_WD-1:0] iresp_data = '0;
  logic               flush = 1'b0;
  logic [PC_WD-1:0]   flush_pc = '0;
  logic [PC_WD-1:0]   ra_data = '0;
  logic               fq_valid;
  logic               fq_ready = 1'b0;
  logic [INST_WD-1:0] fq_inst;
  logic [PC_WD-1:0]   fq_pc;
  logic               fq_pred_taken;
  logic [PC_WD-1:0]   fq_pred_target;
  logic [CNT_WD-1:0]  fq_count;

  ysyx_22041752_ifu_fq #(
    .PC_WD    (PC_WD),
    .INST_WD  (INST_WD),
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (FQ_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_ready     (ireq_ready),
    .ireq_addr      (ireq_addr),
    .iresp_valid    (iresp_valid),
    .iresp_data     (iresp_data),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .ra_data        (ra_data),
    .fq_valid       (fq_valid),
    .fq_ready       (fq_ready),
    .fq_inst        (fq_inst),
    .fq_pc          (fq_pc),
    .fq_pred_taken  (fq_pred_taken),
    .fq_pred_target (fq_pred_target),
    .fq_count       (fq_count)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int rdy_pct = 100;
  int fq_pct = 100;
  int resp_pct = 100;
  bit after_flush = 1'b0;

  logic [EW-1:0]  exp_q[$];
  logic [31:0]    req_q[$];
  logic [31:0]    tbl_inst[64];
  int             tbl_kind[64];   // 0 plain, 1 jal, 2 jalr, 3 branch
  int             tbl_off[64];
  logic [31:0]    model_pc;
  logic [31:0]    cur_ra;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- program image ----------------
  function automatic logic [31:0] enc_jal(input int off);
    logic [20:0] i;
    i = 21'(off);
    return {i[20], i[10:1], i[11], i[19:12], 5'd0, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input int off);
    logic [11:0] i;
    i = 12'(off);
    return {i, 5'd1, 3'b000, 5'd0, 7'b1100111};
  endfunction

  function automatic logic [31:0] enc_br(input int off);
    logic [12:0] i;
    i = 13'(off);
    return {i[12], i[10:5], 5'd2, 5'd1, 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction

  task automatic set_entry(input int idx, input int kind, input int off, input logic [31:0] plain);
    tbl_kind[idx] = kind;
    tbl_off[idx]  = off;
    case (kind)
      1:       tbl_inst[idx] = enc_jal(off);
      2:       tbl_inst[idx] = enc_jalr(off);
      3:       tbl_inst[idx] = enc_br(off);
      default: tbl_inst[idx] = plain;
    endcase
  endtask

  task automatic directed_table();
    for (int i = 0; i < 64; i++) set_entry(i, 0, 0, NOP);
    set_entry(4, 1, 64, NOP);    // 0x10: jal +0x40
    set_entry(20, 3, 8, NOP);    // 0x50: beq +8, falls through
    set_entry(22, 3, -8, NOP);   // 0x58: beq -8, loops back
  endtask

  task automatic random_table();
    for (int i = 0; i < 64; i++) begin
      int r;
      r = int'($urandom_range(99));
      if (r < 30)      set_entry(i, 0, 0, NOP);
      else if (r < 55) set_entry(i, 0, 0, {12'($urandom), 5'd3, 3'b000, 5'($urandom), 7'b0010011});
      else if (r < 65) set_entry(i, 1, 4 * (int'($urandom_range(40)) - 20), NOP);
      else if (r < 75) set_entry(i, 2, int'($urandom_range(127)) - 64, NOP);
      else if (r < 88) set_entry(i, 3, -4 * (1 + int'($urandom_range(15))), NOP);
      else             set_entry(i, 3, 4 * (1 + int'($urandom_range(15))), NOP);
    end
  endtask

  // ---------------- reference model: the predicted program path ----------------
  function automatic logic [EW-1:0] model_entry(input logic [31:0] pc);
    int          idx;
    logic        taken;
    logic [31:0] tgt;
    idx   = int'(pc[7:2]);
    taken = 1'b0;
    tgt   = pc + 32'd4;
    if (tbl_kind[idx] == 1) begin
      taken = 1'b1;
      tgt   = pc + 32'(tbl_off[idx]);
    end else if (tbl_kind[idx] == 2) begin
      taken = 1'b1;
      tgt   = (cur_ra + 32'(tbl_off[idx])) & 32'hFFFF_FFFE;
    end else if (tbl_kind[idx] == 3 && tbl_off[idx] < 0) begin
      taken = 1'b1;
      tgt   = pc + 32'(tbl_off[idx]);
    end
    return {tbl_inst[idx], pc, taken, tgt};
  endfunction

  task automatic gen_one();
    logic [EW-1:0] e;
    e = model_entry(model_pc);
    exp_q.push_back(e);
    model_pc = e[PC_WD-1:0];
  endtask

  task automatic restart(input logic [31:0] pc);
    exp_q.delete();
    model_pc = pc;
    repeat (8) gen_one();
  endtask

  // ---------------- driver ----------------
  task automatic drive_resp();
    logic [31:0] a;
    if (req_q.size() > 0 && int'($urandom_range(99)) < resp_pct) begin
      a = req_q.pop_front();
      iresp_valid = 1'b1;
      iresp_data  = tbl_inst[a[7:2]];
    end else begin
      iresp_valid = 1'b0;
      iresp_data  = $urandom;
    end
  endtask

  task automatic step(input bit fl, input logic [31:0] tgt, input logic [31:0] ra);
    @(negedge clk);
    ireq_ready = (int'($urandom_range(99)) < rdy_pct);
    fq_ready   = (int'($urandom_range(99)) < fq_pct);
    flush      = fl;
    drive_resp();
    if (fl) begin
      flush_pc = tgt;
      ra_data  = ra;
      cur_ra   = ra;
      restart(tgt);
    end
    #2;
    if (after_flush) check("fq_count_after_flush", fq_count, 0);
    if (fl) begin
      check("flush_fq_valid_mask", fq_valid, 0);
      check("flush_ireq_valid_mask", ireq_valid, 0);
    end
    after_flush = fl;
    if (ireq_valid && ireq_ready) req_q.push_back(ireq_addr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("rst_ireq_valid", ireq_valid, 0);
    check("rst_ireq_addr", ireq_addr, RESET_PC);
    check("rst_fq_valid", fq_valid, 0);
    check("rst_fq_count", fq_count, 0);
    check("rst_fq_inst", fq_inst, 0);
    check("rst_fq_pc", fq_pc, 0);
    check("rst_fq_pred", {fq_pred_taken, fq_pred_target}, 0);
    iresp_valid = 1'b0;
    flush       = 1'b0;
    after_flush = 1'b0;
    req_q.delete();
    restart(RESET_PC);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && fq_valid && fq_ready) begin
        while (exp_q.size() < 4) gen_one();
        e = exp_q.pop_front();
        check("fq_entry", {fq_inst, fq_pc, fq_pred_taken, fq_pred_target}, e);
        pops++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    cur_ra  = 32'h8000_0100;
    ra_data = cur_ra;
    directed_table();
    #1 reset = 1'b0;
    do_reset();

    // Straight-line fetch, jal redirect and taken/not-taken branches.
    rdy_pct = 100; fq_pct = 100; resp_pct = 100;
    repeat (30) step(1'b0, '0, '0);

    // Decode stalled: credits run out with the queue full.
    fq_pct = 0;
    repeat (20) step(1'b0, '0, '0);
    check("stall_fq_count", fq_count, FQ_DEPTH);
    check("stall_ireq_valid", ireq_valid, 0);
    fq_pct = 100;
    repeat (20) step(1'b0, '0, '0);

    // Flush with requests outstanding and entries queued.
    fq_pct = 0;
    repeat (3) step(1'b0, '0, '0);
    step(1'b1, 32'h8000_1000, 32'h8000_0200);
    fq_pct = 100;
    repeat (30) step(1'b0, '0, '0);

    // Random traffic on a random program with random flushes.
    random_table();
    step(1'b1, $urandom, $urandom);
    for (int i = 0; i < 2500; i++) begin
      if (i % 50 == 0) begin
        rdy_pct  = 30 + int'($urandom_range(70));
        fq_pct   = 20 + int'($urandom_range(80));
        resp_pct = 30 + int'($urandom_range(70));
      end
      if (i == 1200) begin
        do_reset();
      end else if ($urandom_range(99) < 3) begin
        step(1'b1, $urandom, $urandom);
      end else begin
        step(1'b0, '0, '0);
      end
    end

    // Reset while a request is held waiting for the I-cache.
    rdy_pct = 0; fq_pct = 100; resp_pct = 100;
    repeat (10) step(1'b0, '0, '0);
    check("held_ireq_valid", ireq_valid, 1);
    do_reset();
    rdy_pct = 100;
    repeat (20) step(1'b0, '0, '0);

    checks++;
    if (pops < 300) begin
      errors++;
      $display("FAIL progress: got %0d entries consumed expected at least 300", pops);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
